// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU and its two-port arbiter.
//   alu_op_t     - 5-bit ALU operation code
//   ALU_*        - legal operation codes
//   arb_state_t  - arbiter state machine encoding
package alu_pkg;

  typedef logic [4:0] alu_op_t;

  localparam alu_op_t ALU_LSL = 5'b10000;
  localparam alu_op_t ALU_LSR = 5'b10001;
  localparam alu_op_t ALU_AND = 5'b00000;
  localparam alu_op_t ALU_OR  = 5'b00001;
  localparam alu_op_t ALU_NOT = 5'b00010;
  localparam alu_op_t ALU_XOR = 5'b00011;
  localparam alu_op_t ALU_ADD = 5'b00100;
  localparam alu_op_t ALU_SUB = 5'b00101;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

endpackage

// File: rtl/alu.sv
// alu: purely combinational 8-bit datapath.
//   op     in  OPW    operation code
//   a, b   in  WIDTH  operands
//   result out WIDTH  result; all-ones for any code that is not decoded
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OPW   = 5
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '1;
    case (op)
      // Shift amount is the whole of b, so b >= WIDTH shifts everything out.
      ALU_LSL: result = a << b;
      ALU_LSR: result = a >> b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      // Logical not: 1 when a is zero.
      ALU_NOT: result = (a == '0) ? WIDTH'(1) : '0;
      ALU_XOR: result = a ^ b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      default: result = '1;
    endcase
  end

endmodule

// File: rtl/rr_pick2.sv
// rr_pick2: two-input round-robin picker, purely combinational.
//   valid0, valid1 in  requests from port 0 / port 1
//   last_grant     in  index of the port granted most recently
//   grant          out one-hot grant, bit N for port N (zero when no request)
module rr_pick2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) begin
      // Tie: favour the port that did not win last time.
      grant = last_grant ? 2'b01 : 2'b10;
    end else if (valid0) begin
      grant = 2'b01;
    end else if (valid1) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one alu between two requesters.
//   clk, rst_n                     clock, synchronous active-low reset
//   reqN_valid/ready/op/a/b (N=0,1) operation request handshake
//   rspN_valid/ready                result handshake
//   rspN_data/zero/err              registered result, zero flag, illegal-op flag
// One transaction in flight at a time: IDLE (accept) -> EXEC (compute) -> RESP (hold).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OPW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_zero,
  output logic             rsp0_err,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_zero,
  output logic             rsp1_err
);

  arb_state_t       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             gnt_id_q, gnt_id_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic [1:0]       grant;
  logic [WIDTH-1:0] alu_result;
  logic             op_legal;

  rr_pick2 u_rr_pick2 (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  alu #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result)
  );

  always_comb begin
    op_legal = 1'b0;
    case (op_q)
      ALU_LSL, ALU_LSR, ALU_AND, ALU_OR,
      ALU_NOT, ALU_XOR, ALU_ADD, ALU_SUB: op_legal = 1'b1;
      default:                            op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_id_d     = gnt_id_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    data_d       = data_q;
    zero_d       = zero_q;
    err_d        = err_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Ready is the grant itself, so a nonzero grant is the handshake.
        req0_ready = grant[0];
        req1_ready = grant[1];
        if (grant != 2'b00) begin
          gnt_id_d     = grant[1];
          last_grant_d = grant[1];
          op_d         = grant[1] ? req1_op : req0_op;
          a_d          = grant[1] ? req1_a  : req0_a;
          b_d          = grant[1] ? req1_b  : req0_b;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        data_d  = alu_result;
        zero_d  = (alu_result == '0);
        err_d   = ~op_legal;
        state_d = RESP;
      end
      RESP: begin
        rsp0_valid = ~gnt_id_q;
        rsp1_valid = gnt_id_q;
        if (gnt_id_q ? rsp1_ready : rsp0_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      // Port 0 wins the first tie after reset.
      last_grant_q <= 1'b1;
      gnt_id_q     <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      data_q       <= '0;
      zero_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_id_q     <= gnt_id_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      data_q       <= data_d;
      zero_q       <= zero_d;
      err_q        <= err_d;
    end
  end

  assign rsp0_data = data_q;
  assign rsp0_zero = zero_q;
  assign rsp0_err  = err_q;
  assign rsp1_data = data_q;
  assign rsp1_zero = zero_q;
  assign rsp1_err  = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter. Expected results are pushed when a
// request is accepted and popped when the matching response is seen.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [7:0] rsp0_data, rsp1_data;
  logic       rsp0_zero, rsp0_err, rsp1_zero, rsp1_err;

  typedef struct {
    logic       port;
    logic [7:0] data;
    logic       zero;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  // Edge-op table: op, a, b -> data, zero, err
  logic [4:0] e_op  [8] = '{ALU_LSL, ALU_NOT, ALU_NOT, 5'b00111,
                           ALU_LSL, ALU_SUB, ALU_OR, ALU_LSR};
  logic [7:0] e_a   [8] = '{8'h01, 8'h00, 8'h3C, 8'h12, 8'h01, 8'h00, 8'h0F, 8'hFF};
  logic [7:0] e_b   [8] = '{8'h08, 8'h55, 8'h00, 8'h34, 8'h07, 8'h01, 8'hF0, 8'hC8};
  logic [7:0] e_dat [8] = '{8'h00, 8'h01, 8'h00, 8'hFF, 8'h80, 8'hFF, 8'hFF, 8'h00};
  logic       e_zer [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       e_err [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(8), .OPW(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .rsp0_zero  (rsp0_zero),
    .rsp0_err   (rsp0_err),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data),
    .rsp1_zero  (rsp1_zero),
    .rsp1_err   (rsp1_err)
  );

  // Present a request from the next falling edge until accepted (bounded), then drop valid
  // just after the accepting rising edge.
  task automatic send(input int port, input logic [4:0] op, input logic [7:0] a,
                      input logic [7:0] b, input int budget, output bit ok);
    @(negedge clk);
    if (port == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      #1;
      if ((port == 0) ? req0_ready : req1_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    if (port == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  // Wait (bounded) for a response on a port; lat counts falling edges since the accept.
  task automatic get_rsp(input int port, input int budget, output bit seen, output int lat);
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      #1;
      if ((port == 0) ? rsp0_valid : rsp1_valid) begin
        seen = 1'b1;
        lat  = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_handshake: got %b required 0000",
               {req0_ready, req1_ready, rsp0_valid, rsp1_valid});
    end
    checks++;
    if ({rsp0_data, rsp0_zero, rsp0_err, rsp1_data, rsp1_zero, rsp1_err} !== 20'h0) begin
      failures++;
      $display("FAIL reset_data: got %h/%b/%b %h/%b/%b required zeros",
               rsp0_data, rsp0_zero, rsp0_err, rsp1_data, rsp1_zero, rsp1_err);
    end
    // Tie under reset: combinational grant to port 0, but no handshake takes effect.
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      failures++;
      $display("FAIL reset_tie_grant: got ready1,0=%b required 01", {req1_ready, req0_ready});
    end
    @(negedge clk);
    #1;
    checks++;
    if ({req1_ready, req0_ready, rsp0_valid, rsp1_valid} !== 4'b0100) begin
      failures++;
      $display("FAIL reset_priority: got %b required 0100",
               {req1_ready, req0_ready, rsp0_valid, rsp1_valid});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single_add();
    bit ok, seen;
    int lat;
    exp_t e;
    send(0, ALU_ADD, 8'hF0, 8'h20, 4, ok);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL add_accept: got accepted=%b required 1", ok);
    end else begin
      sb.push_back('{port: 1'b0, data: 8'h10, zero: 1'b0, err: 1'b0});
    end
    get_rsp(0, 8, seen, lat);
    checks++;
    if (!seen || lat != 2 || rsp1_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_latency: got seen=%b lat=%0d rsp1_valid=%b required 1/2/0",
               seen, lat, rsp1_valid);
    end
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({rsp0_data, rsp0_zero, rsp0_err} !== {e.data, e.zero, e.err}) begin
        failures++;
        $display("FAIL add_result: got %h/%b/%b required %h/%b/%b",
                 rsp0_data, rsp0_zero, rsp0_err, e.data, e.zero, e.err);
      end
    end
  endtask

  task automatic test_round_robin();
    int   g[$];
    int   exp_g[3] = '{0, 1, 0};
    exp_t e;
    logic [7:0] d;
    logic       z, er;
    do_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_op = ALU_SUB; req0_a = 8'h05; req0_b = 8'h05;
    req1_valid = 1'b1; req1_op = ALU_XOR; req1_a = 8'hAA; req1_b = 8'h55;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (req0_ready && req1_ready) begin
        checks++; failures++;
        $display("FAIL rr_one_hot: got both readies high required one");
      end
      if (req0_ready) begin
        g.push_back(0);
        sb.push_back('{port: 1'b0, data: 8'h00, zero: 1'b1, err: 1'b0});
      end
      if (req1_ready) begin
        g.push_back(1);
        sb.push_back('{port: 1'b1, data: 8'hFF, zero: 1'b0, err: 1'b0});
      end
      if (rsp0_valid || rsp1_valid) begin
        checks++;
        if (sb.size() == 0 || (rsp0_valid && rsp1_valid)) begin
          failures++;
          $display("FAIL rr_unexpected_rsp: got rsp0/1_valid=%b%b queue=%0d",
                   rsp0_valid, rsp1_valid, sb.size());
        end else begin
          e  = sb.pop_front();
          d  = rsp1_valid ? rsp1_data : rsp0_data;
          z  = rsp1_valid ? rsp1_zero : rsp0_zero;
          er = rsp1_valid ? rsp1_err  : rsp0_err;
          if ({rsp1_valid, d, z, er} !== {e.port, e.data, e.zero, e.err}) begin
            failures++;
            $display("FAIL rr_result: got port%0d %h/%b/%b required port%0d %h/%b/%b",
                     rsp1_valid, d, z, er, e.port, e.data, e.zero, e.err);
          end
        end
      end
      if (g.size() >= 3 && sb.size() == 0) break;
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (g.size() != 3 || sb.size() != 0) begin
      failures++;
      $display("FAIL rr_count: got grants=%0d pending=%0d required 3/0", g.size(), sb.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (((i < g.size()) ? g[i] : -1) != exp_g[i]) begin
        failures++;
        $display("FAIL rr_order_%0d: got %0d required %0d", i,
                 (i < g.size()) ? g[i] : -1, exp_g[i]);
      end
    end
  endtask

  task automatic test_back_pressure();
    bit ok, seen;
    int lat;
    exp_t e;
    rsp0_ready = 1'b1; rsp1_ready = 1'b0;
    send(1, ALU_LSR, 8'h80, 8'h03, 4, ok);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL bp_accept: got accepted=%b required 1", ok);
    end else begin
      sb.push_back('{port: 1'b1, data: 8'h10, zero: 1'b0, err: 1'b0});
    end
    get_rsp(1, 8, seen, lat);
    checks++;
    if (!seen || lat != 2) begin
      failures++;
      $display("FAIL bp_latency: got seen=%b lat=%0d required 1/2", seen, lat);
    end
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({rsp1_data, rsp1_zero, rsp1_err} !== {e.data, e.zero, e.err}) begin
        failures++;
        $display("FAIL bp_result: got %h/%b/%b required %h/%b/%b",
                 rsp1_data, rsp1_zero, rsp1_err, e.data, e.zero, e.err);
      end
    end
    // Port 0 waits while port 1 holds its response.
    req0_valid = 1'b1; req0_op = ALU_AND; req0_a = 8'hFF; req0_b = 8'h0F;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if ({rsp1_valid, rsp0_valid, rsp1_data, req0_ready, req1_ready} !== {2'b10, 8'h10, 2'b00})
      begin
        failures++;
        $display("FAIL bp_hold_%0d: got v1=%b v0=%b data=%h r0=%b r1=%b required 1/0/10/0/0",
                 k, rsp1_valid, rsp0_valid, rsp1_data, req0_ready, req1_ready);
      end
      @(negedge clk);
    end
    rsp1_ready = 1'b1;
    #1;
    checks++;
    if ({rsp1_valid, req0_ready} !== 2'b10) begin
      failures++;
      $display("FAIL bp_release_same_cycle: got v1=%b r0=%b required 1/0", rsp1_valid, req0_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_next_accept: got req0_ready=%b required 1", req0_ready);
    end else begin
      sb.push_back('{port: 1'b0, data: 8'h0F, zero: 1'b0, err: 1'b0});
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    get_rsp(0, 8, seen, lat);
    checks++;
    if (!seen || lat != 2 || sb.size() == 0) begin
      failures++;
      $display("FAIL bp_port0_rsp: got seen=%b lat=%0d queue=%0d required 1/2/1",
               seen, lat, sb.size());
    end else begin
      e = sb.pop_front();
      checks++;
      if ({rsp0_data, rsp0_zero, rsp0_err} !== {e.data, e.zero, e.err}) begin
        failures++;
        $display("FAIL bp_port0_result: got %h/%b/%b required %h/%b/%b",
                 rsp0_data, rsp0_zero, rsp0_err, e.data, e.zero, e.err);
      end
    end
  endtask

  task automatic test_edge_ops();
    bit ok, seen;
    int lat;
    exp_t e;
    rsp0_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(0, e_op[i], e_a[i], e_b[i], 4, ok);
      if (ok) sb.push_back('{port: 1'b0, data: e_dat[i], zero: e_zer[i], err: e_err[i]});
      get_rsp(0, 8, seen, lat);
      checks++;
      if (!ok || !seen || lat != 2 || sb.size() == 0) begin
        failures++;
        $display("FAIL edge_%0d_handshake: got ok=%b seen=%b lat=%0d required 1/1/2",
                 i, ok, seen, lat);
      end else begin
        e = sb.pop_front();
        checks++;
        if ({rsp0_data, rsp0_zero, rsp0_err} !== {e.data, e.zero, e.err}) begin
          failures++;
          $display("FAIL edge_%0d_result: op=%b a=%h b=%h got %h/%b/%b required %h/%b/%b",
                   i, e_op[i], e_a[i], e_b[i], rsp0_data, rsp0_zero, rsp0_err,
                   e.data, e.zero, e.err);
        end
      end
    end
  endtask

  task automatic test_reset_mid_op();
    bit ok, seen;
    bit any_rsp;
    int lat;
    exp_t e;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    send(0, ALU_ADD, 8'h01, 8'h01, 4, ok);
    if (ok) sb.push_back('{port: 1'b0, data: 8'h02, zero: 1'b0, err: 1'b0});
    // Now in EXEC: reset discards the transaction.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    sb.delete();
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp0_data, rsp0_zero, rsp0_err, req0_ready, req1_ready}
        !== 14'h0) begin
      failures++;
      $display("FAIL midreset_outputs: got v=%b%b data=%h z=%b e=%b r=%b%b required zeros",
               rsp0_valid, rsp1_valid, rsp0_data, rsp0_zero, rsp0_err, req0_ready, req1_ready);
    end
    rst_n = 1'b1;
    any_rsp = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      any_rsp = any_rsp | rsp0_valid | rsp1_valid;
    end
    checks++;
    if (any_rsp !== 1'b0) begin
      failures++;
      $display("FAIL midreset_no_rsp: got a response required none");
    end
    req1_valid = 1'b1; req1_op = ALU_XOR; req1_a = 8'h0F; req1_b = 8'h0F;
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_accept: got req1_ready=%b required 1", req1_ready);
    end else begin
      sb.push_back('{port: 1'b1, data: 8'h00, zero: 1'b1, err: 1'b0});
    end
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    get_rsp(1, 8, seen, lat);
    checks++;
    if (!seen || lat != 2 || sb.size() == 0) begin
      failures++;
      $display("FAIL midreset_rsp: got seen=%b lat=%0d required 1/2", seen, lat);
    end else begin
      e = sb.pop_front();
      checks++;
      if ({rsp1_data, rsp1_zero, rsp1_err} !== {e.data, e.zero, e.err}) begin
        failures++;
        $display("FAIL midreset_result: got %h/%b/%b required %h/%b/%b",
                 rsp1_data, rsp1_zero, rsp1_err, e.data, e.zero, e.err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_round_robin();
    test_back_pressure();
    test_edge_ops();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
